// File: rtl/token_stream_pkg.sv
`default_nettype none
// ============================================================================
// Module  : token_stream_pkg
// Purpose : Shared types and helpers for the serial token-stream blocks.
// Rev     : 1.0  initial release
// ============================================================================
package token_stream_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } token_state_t;

  function automatic int pend_w(input int max);
    return $clog2(max + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/double_tokens_backlog_if.sv
`default_nettype none
// ============================================================================
// Module  : double_tokens_backlog_if
// Purpose : Token stream bundle: input token, output token, status outputs.
// Rev     : 1.0  initial release
// ============================================================================
interface double_tokens_backlog_if
  import token_stream_pkg::*;
#(
  parameter int MAX_PENDING = 200
);
  localparam int PW = pend_w(MAX_PENDING);

  logic          a;
  logic          b;
  logic          overflow;
  logic [PW-1:0] pending;

  modport master (output a, input b, input overflow, input pending);
  modport slave  (input a, output b, output overflow, output pending);

endinterface
`default_nettype wire

// File: rtl/token_backlog_counter.sv
`default_nettype none
// ============================================================================
// Module  : token_backlog_counter
// Purpose : Holds the backlog depth, decides acceptance, drains one per cycle.
// Rev     : 1.0  initial release
// ============================================================================
module token_backlog_counter
  import token_stream_pkg::*;
#(
  parameter int MULT        = 2,
  parameter int MAX_PENDING = 200
) (
  input  wire logic                            clk,
  input  wire logic                            rst,
  input  wire logic                            a_i,
  output logic                                 accept_o,
  output logic [pend_w(MAX_PENDING)-1:0]       pending_o
);

  localparam int PW = pend_w(MAX_PENDING);

  // One extra bit so P + MULT never wraps before the limit compare.
  localparam logic [PW:0]   c_mult_w  = (PW+1)'(MULT);
  localparam logic [PW:0]   c_limit   = (PW+1)'(MAX_PENDING + 1);
  localparam logic [PW-1:0] c_mult_m1 = PW'(MULT - 1);

  logic [PW-1:0] pending_q, pending_d;
  logic [PW:0]   w_sum;
  logic          w_accept;

  assign w_sum    = {1'b0, pending_q} + c_mult_w;
  assign w_accept = a_i && (w_sum <= c_limit);

  always_comb begin
    pending_d = pending_q;
    if (w_accept) begin
      pending_d = pending_q + c_mult_m1;
    end else if (pending_q != '0) begin
      pending_d = pending_q - PW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign accept_o  = w_accept;
  assign pending_o = pending_q;

endmodule
`default_nettype wire

// File: rtl/double_tokens_backlog.sv
`default_nettype none
// ============================================================================
// Module  : double_tokens_backlog
// Purpose : Emits MULT output tokens per input token through a bounded backlog.
// Rev     : 1.0  initial release
// ============================================================================
module double_tokens_backlog
  import token_stream_pkg::*;
#(
  parameter int MULT        = 2,
  parameter int MAX_PENDING = 200
) (
  input  wire logic               clk,
  input  wire logic               rst,
  double_tokens_backlog_if.slave  tok
);

  localparam int PW = pend_w(MAX_PENDING);

  generate
    if (MULT < 1 || MULT > MAX_PENDING) begin : g_bad_params
      $error("double_tokens_backlog: MULT must lie in 1..MAX_PENDING");
    end
  endgenerate

  logic          w_accept;
  logic [PW-1:0] w_pending;
  logic          w_next_busy;
  logic          w_b;

  token_state_t state_q, state_d;
  logic         overflow_q, overflow_d;

  token_backlog_counter #(
    .MULT        (MULT),
    .MAX_PENDING (MAX_PENDING)
  ) u_counter (
    .clk       (clk),
    .rst       (rst),
    .a_i       (tok.a),
    .accept_o  (w_accept),
    .pending_o (w_pending)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      overflow_q <= overflow_d;
    end
  end

  // Next backlog is non-zero after an accept unless MULT=1 from empty; else only if P > 1.
  assign w_next_busy = w_accept ? ((MULT > 1) || (w_pending != '0))
                                : (w_pending > PW'(1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (w_accept && w_next_busy) state_d = BUSY;
      BUSY:    if (!w_next_busy)            state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    overflow_d = overflow_q | (tok.a & ~w_accept);
    w_b        = ~rst & (w_accept | (state_q == BUSY));
  end

  assign tok.b        = w_b;
  assign tok.overflow = overflow_q;
  assign tok.pending  = w_pending;

endmodule
`default_nettype wire

// File: tb/tb_double_tokens_backlog.sv
`default_nettype none
// ============================================================================
// Module  : tb_double_tokens_backlog
// Purpose : Directed checks of the token expander for MULT = 2, 3 and 1.
// Rev     : 1.0  initial release
// ============================================================================
module tb_double_tokens_backlog;

  logic clk;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  double_tokens_backlog_if #(.MAX_PENDING(4)) if_m2 ();
  double_tokens_backlog_if #(.MAX_PENDING(4)) if_m3 ();
  double_tokens_backlog_if #(.MAX_PENDING(4)) if_m1 ();

  double_tokens_backlog #(.MULT(2), .MAX_PENDING(4)) u_dut_m2 (.clk(clk), .rst(rst), .tok(if_m2));
  double_tokens_backlog #(.MULT(3), .MAX_PENDING(4)) u_dut_m3 (.clk(clk), .rst(rst), .tok(if_m3));
  double_tokens_backlog #(.MULT(1), .MAX_PENDING(4)) u_dut_m1 (.clk(clk), .rst(rst), .tok(if_m1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive_a(input int sel, input logic v);
    case (sel)
      2:       if_m2.a = v;
      3:       if_m3.a = v;
      default: if_m1.a = v;
    endcase
  endtask

  function automatic logic get_b(input int sel);
    case (sel)
      2:       return if_m2.b;
      3:       return if_m3.b;
      default: return if_m1.b;
    endcase
  endfunction

  function automatic int get_p(input int sel);
    case (sel)
      2:       return int'(if_m2.pending);
      3:       return int'(if_m3.pending);
      default: return int'(if_m1.pending);
    endcase
  endfunction

  function automatic logic get_o(input int sel);
    case (sel)
      2:       return if_m2.overflow;
      3:       return if_m3.overflow;
      default: return if_m1.overflow;
    endcase
  endfunction

  // One cycle: drive a at negedge, check b before the edge, pending/overflow after it.
  task automatic step(input int sel, input string tag, input logic av,
                      input logic eb, input int ep, input logic eo);
    @(negedge clk);
    drive_a(sel, av);
    #1;
    check($sformatf("%s b", tag), 32'(get_b(sel)), 32'(eb));
    @(posedge clk);
    #1;
    check($sformatf("%s pending", tag), 32'(get_p(sel)), 32'(ep));
    check($sformatf("%s overflow", tag), 32'(get_o(sel)), 32'(eo));
  endtask

  localparam logic [7:0] T1_A = 8'b1100_0000;
  localparam logic [7:0] T1_B = 8'b1111_0000;
  localparam int T1_P [8] = '{1, 2, 1, 0, 0, 0, 0, 0};
  localparam int T2_P [8] = '{1, 2, 3, 4, 3, 4, 3, 4};
  localparam logic [7:0] T2_O = 8'b0000_1111;

  initial begin
    logic av;
    rst = 1'b1;
    if_m2.a = 1'b1;
    if_m3.a = 1'b0;
    if_m1.a = 1'b1;
    #12;
    check("reset m2 b gated", 32'(if_m2.b), 32'd0);
    check("reset m1 b gated", 32'(if_m1.b), 32'd0);
    check("reset m2 pending", 32'(if_m2.pending), 32'd0);
    check("reset m2 overflow", 32'(if_m2.overflow), 32'd0);
    check("reset m3 pending", 32'(if_m3.pending), 32'd0);
    @(negedge clk);
    if_m2.a = 1'b0;
    if_m1.a = 1'b0;
    rst = 1'b0;

    for (int i = 0; i < 8; i++)
      step(2, $sformatf("pair[%0d]", i), T1_A[7-i], T1_B[7-i], T1_P[i], 1'b0);

    for (int i = 0; i < 8; i++)
      step(2, $sformatf("held[%0d]", i), 1'b1, 1'b1, T2_P[i], T2_O[7-i]);
    for (int i = 0; i < 4; i++)
      step(2, $sformatf("drain[%0d]", i), 1'b0, 1'b1, 3 - i, 1'b1);

    for (int i = 0; i < 20; i++)
      step(2, $sformatf("idle[%0d]", i), 1'b0, 1'b0, 0, 1'b1);
    step(2, "repulse0", 1'b1, 1'b1, 1, 1'b1);
    step(2, "repulse1", 1'b0, 1'b1, 0, 1'b1);

    step(3, "m3[0]", 1'b1, 1'b1, 2, 1'b0);
    step(3, "m3[1]", 1'b0, 1'b1, 1, 1'b0);
    step(3, "m3[2]", 1'b0, 1'b1, 0, 1'b0);
    step(3, "m3[3]", 1'b0, 1'b0, 0, 1'b0);

    for (int i = 0; i < 64; i++) begin
      av = 1'($urandom_range(0, 1));
      step(1, $sformatf("m1[%0d]", i), av, av, 0, 1'b0);
    end

    step(2, "build0", 1'b1, 1'b1, 1, 1'b1);
    step(2, "build1", 1'b1, 1'b1, 2, 1'b1);
    step(2, "build2", 1'b1, 1'b1, 3, 1'b1);
    #2;
    if_m2.a = 1'b1;
    rst = 1'b1;
    #1;
    check("midrst b", 32'(if_m2.b), 32'd0);
    check("midrst pending", 32'(if_m2.pending), 32'd0);
    check("midrst overflow", 32'(if_m2.overflow), 32'd0);
    @(negedge clk);
    if_m2.a = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 4; i++)
      step(2, $sformatf("postrst[%0d]", i), 1'b0, 1'b0, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
